// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Serial frame receiver. Waits for a start bit on serIn, then
//               shifts in MSB first a channel-address header, a length field
//               and a variable-length payload, and finally checks a stop bit.
//               A good frame is presented on a parallel bus together with a
//               one-hot per-channel valid pulse. A bad frame raises a
//               one-cycle frame_err with a reason code.
//
//               Optional feature (compile-time macro SERIAL_FRAME_RX_PARITY_EN):
//               an even-parity bit follows the payload. It covers the
//               address, length and payload bits.
//
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               serIn      - serial line, idles high
//               shEn       - high in every cycle a header/payload bit is sampled
//               busy       - high whenever the receiver is not idle
//               done       - one-cycle pulse, good frame delivered
//               ch_addr    - channel of last good frame
//               data_len   - payload length of last good frame
//               data_out   - payload, right-aligned, upper bits zero
//               ch_valid   - one-hot copy of ch_addr, high only with done
//               frame_err  - one-cycle pulse, bad frame
//               err_code   - 01 stop, 10 length overflow, 11 parity
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int CH_ADDR_W = 2,
    parameter int LEN_W     = 4,
    parameter int DATA_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serIn,
    output logic                      shEn,
    output logic                      busy,
    output logic                      done,
    output logic [CH_ADDR_W-1:0]      ch_addr,
    output logic [LEN_W-1:0]          data_len,
    output logic [DATA_W-1:0]         data_out,
    output logic [(2**CH_ADDR_W)-1:0] ch_valid,
    output logic                      frame_err,
    output logic [1:0]                err_code
);

    localparam int c_NUM_CH   = 2**CH_ADDR_W;
    localparam int c_HDR_BITS = CH_ADDR_W + LEN_W;
    localparam int c_MAX_LEN  = 2**LEN_W - 1;
    // One counter serves both header and payload, so it must hold the
    // larger of the two bit counts.
    localparam int c_CNT_MAX  = (c_HDR_BITS > c_MAX_LEN) ? c_HDR_BITS : c_MAX_LEN;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_HDR_LAST = c_CNT_W'(c_HDR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_STOP    = 3'd3,
        S_RESYNC  = 3'd4
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ,
        S_PARITY  = 3'd5
`endif
    } state_t;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam state_t c_AFTER_DATA = S_PARITY;
`else
    localparam state_t c_AFTER_DATA = S_STOP;
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                r_state_q,     w_state_d;
    logic [c_CNT_W-1:0]    r_cnt_q,       w_cnt_d;
    logic [c_HDR_BITS-1:0] r_hdr_q,       w_hdr_d;
    logic [DATA_W-1:0]     r_shreg_q,     w_shreg_d;
    logic                  r_ovf_q,       w_ovf_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                  r_par_q,       w_par_d;
    logic                  r_par_err_q,   w_par_err_d;
`endif

    logic                  r_shen_q,      w_shen_d;
    logic                  r_busy_q,      w_busy_d;
    logic                  r_done_q,      w_done_d;
    logic [CH_ADDR_W-1:0]  r_ch_addr_q,   w_ch_addr_d;
    logic [LEN_W-1:0]      r_data_len_q,  w_data_len_d;
    logic [DATA_W-1:0]     r_data_out_q,  w_data_out_d;
    logic [c_NUM_CH-1:0]   r_ch_valid_q,  w_ch_valid_d;
    logic                  r_frame_err_q, w_frame_err_d;
    logic [1:0]            r_err_code_q,  w_err_code_d;

    // ------------------------------------------------------------------
    // Helper views of the header register
    // ------------------------------------------------------------------
    logic [c_HDR_BITS-1:0] w_hdr_shift;   // header including the bit being sampled now
    logic [LEN_W-1:0]      w_len_new;     // length field as it completes in HDR
    logic [LEN_W-1:0]      w_len_cur;     // length field once the header is complete
    logic [CH_ADDR_W-1:0]  w_addr_cur;    // address field once the header is complete
    logic [c_CNT_W-1:0]    w_cnt_inc;

    assign w_hdr_shift = {r_hdr_q[c_HDR_BITS-2:0], serIn};
    assign w_len_new   = w_hdr_shift[LEN_W-1:0];
    assign w_len_cur   = r_hdr_q[LEN_W-1:0];
    assign w_addr_cur  = r_hdr_q[c_HDR_BITS-1:LEN_W];
    assign w_cnt_inc   = r_cnt_q + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_hdr_d       = r_hdr_q;
        w_shreg_d     = r_shreg_q;
        w_ovf_d       = r_ovf_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        w_par_d       = r_par_q;
        w_par_err_d   = r_par_err_q;
`endif
        w_ch_addr_d   = r_ch_addr_q;
        w_data_len_d  = r_data_len_q;
        w_data_out_d  = r_data_out_q;
        // Pulse outputs fall back to zero every cycle
        w_done_d      = 1'b0;
        w_ch_valid_d  = '0;
        w_frame_err_d = 1'b0;
        w_err_code_d  = 2'b00;

        case (r_state_q)
            S_IDLE: begin
                if (!serIn) begin
                    // Start bit: clear all per-frame context
                    w_state_d   = S_HDR;
                    w_cnt_d     = '0;
                    w_hdr_d     = '0;
                    w_shreg_d   = '0;
                    w_ovf_d     = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    w_par_d     = 1'b0;
                    w_par_err_d = 1'b0;
`endif
                end
            end

            S_HDR: begin
                w_hdr_d = w_hdr_shift;
                w_cnt_d = w_cnt_inc;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                w_par_d = r_par_q ^ serIn;
`endif
                if (r_cnt_q == c_HDR_LAST) begin
                    w_cnt_d   = '0;
                    // Longer payloads are still consumed; only the tail is kept
                    w_ovf_d   = (int'(w_len_new) > DATA_W);
                    w_state_d = (w_len_new != '0) ? S_PAYLOAD : c_AFTER_DATA;
                end
            end

            S_PAYLOAD: begin
                w_shreg_d = {r_shreg_q[DATA_W-2:0], serIn};
                w_cnt_d   = w_cnt_inc;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                w_par_d   = r_par_q ^ serIn;
`endif
                if (w_cnt_inc == c_CNT_W'(w_len_cur)) begin
                    w_cnt_d   = '0;
                    w_state_d = c_AFTER_DATA;
                end
            end

`ifdef SERIAL_FRAME_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: running XOR plus parity bit must be zero
                w_par_err_d = r_par_q ^ serIn;
                w_state_d   = S_STOP;
            end
`endif

            S_STOP: begin
                w_state_d = S_IDLE;
                if (!serIn) begin
                    w_frame_err_d = 1'b1;
                    w_err_code_d  = 2'b01;
                    w_state_d     = S_RESYNC;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                end else if (r_par_err_q) begin
                    w_frame_err_d = 1'b1;
                    w_err_code_d  = 2'b11;
`endif
                end else if (r_ovf_q) begin
                    w_frame_err_d = 1'b1;
                    w_err_code_d  = 2'b10;
                end else begin
                    w_done_d     = 1'b1;
                    w_ch_addr_d  = w_addr_cur;
                    w_data_len_d = w_len_cur;
                    w_data_out_d = r_shreg_q;
                    for (int i = 0; i < c_NUM_CH; i++) begin
                        w_ch_valid_d[i] = (w_addr_cur == CH_ADDR_W'(i));
                    end
                end
            end

            S_RESYNC: begin
                // A low line here is the tail of a broken frame, never a start bit
                if (serIn) begin
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state
        w_shen_d = (w_state_d == S_HDR) || (w_state_d == S_PAYLOAD);
        w_busy_d = (w_state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_hdr_q       <= '0;
            r_shreg_q     <= '0;
            r_ovf_q       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_par_q       <= 1'b0;
            r_par_err_q   <= 1'b0;
`endif
            r_shen_q      <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_ch_addr_q   <= '0;
            r_data_len_q  <= '0;
            r_data_out_q  <= '0;
            r_ch_valid_q  <= '0;
            r_frame_err_q <= 1'b0;
            r_err_code_q  <= 2'b00;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_hdr_q       <= w_hdr_d;
            r_shreg_q     <= w_shreg_d;
            r_ovf_q       <= w_ovf_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_par_q       <= w_par_d;
            r_par_err_q   <= w_par_err_d;
`endif
            r_shen_q      <= w_shen_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
            r_ch_addr_q   <= w_ch_addr_d;
            r_data_len_q  <= w_data_len_d;
            r_data_out_q  <= w_data_out_d;
            r_ch_valid_q  <= w_ch_valid_d;
            r_frame_err_q <= w_frame_err_d;
            r_err_code_q  <= w_err_code_d;
        end
    end

    assign shEn      = r_shen_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;
    assign ch_addr   = r_ch_addr_q;
    assign data_len  = r_data_len_q;
    assign data_out  = r_data_out_q;
    assign ch_valid  = r_ch_valid_q;
    assign frame_err = r_frame_err_q;
    assign err_code  = r_err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Directed self-checking bench for serial_frame_rx (default
//               parameters, parity disabled). Bits are driven on the falling
//               edge; outputs are observed on the falling edge just before
//               the next bit is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       serIn;
    logic       shEn;
    logic       busy;
    logic       done;
    logic [1:0] ch_addr;
    logic [3:0] data_len;
    logic [7:0] data_out;
    logic [3:0] ch_valid;
    logic       frame_err;
    logic [1:0] err_code;

    serial_frame_rx #(
        .CH_ADDR_W (2),
        .LEN_W     (4),
        .DATA_W    (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .serIn     (serIn),
        .shEn      (shEn),
        .busy      (busy),
        .done      (done),
        .ch_addr   (ch_addr),
        .data_len  (data_len),
        .data_out  (data_out),
        .ch_valid  (ch_valid),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation bookkeeping updated once per driven bit
    int         cyc       = 0;
    int         sh_cnt    = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         stray_vld = 0;
    logic [1:0] last_err  = 2'b00;
    int         snap_cyc  [8];
    int         snap_sh   [8];
    logic [1:0] snap_addr [8];
    logic [3:0] snap_len  [8];
    logic [7:0] snap_data [8];
    logic [3:0] snap_vld  [8];
    int         c0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe outputs for the cycle just ending, then drive the next bit
    task automatic drive(input logic b);
        @(negedge clk);
        cyc++;
        if (shEn) sh_cnt++;
        if (!done && ch_valid != 4'b0000) stray_vld++;
        if (done) begin
            if (done_cnt < 8) begin
                snap_cyc[done_cnt]  = cyc;
                snap_sh[done_cnt]   = sh_cnt;
                snap_addr[done_cnt] = ch_addr;
                snap_len[done_cnt]  = data_len;
                snap_data[done_cnt] = data_out;
                snap_vld[done_cnt]  = ch_valid;
            end
            done_cnt++;
            sh_cnt = 0;
        end
        if (frame_err) begin
            err_cnt++;
            last_err = err_code;
        end
        serIn = b;
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(bits[i]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        serIn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle line after reset
        repeat (10) drive(1'b1);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_done",      32'(done),      32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_shEn",      32'(shEn),      32'd0);
        check_eq("rst_ch_addr",   32'(ch_addr),   32'd0);
        check_eq("rst_data_len",  32'(data_len),  32'd0);
        check_eq("rst_data_out",  32'(data_out),  32'd0);
        check_eq("rst_ch_valid",  32'(ch_valid),  32'd0);
        check_eq("rst_err_code",  32'(err_code),  32'd0);

        // Two good frames back to back: addr 2 len 5 payload 10110, then addr 1 len 0
        sh_cnt = 0;
        c0     = cyc;
        send(32'b0_10_0101_10110_1, 13);
        send(32'b0_01_0000_1, 8);
        drive(1'b1);
        drive(1'b1);
        check_eq("f1f2_done_cnt", 32'(done_cnt),     32'd2);
        check_eq("f1_latency",    32'(snap_cyc[0]),  32'(c0 + 14));
        check_eq("f1_shEn_cnt",   32'(snap_sh[0]),   32'd11);
        check_eq("f1_ch_addr",    32'(snap_addr[0]), 32'd2);
        check_eq("f1_data_len",   32'(snap_len[0]),  32'd5);
        check_eq("f1_data_out",   32'(snap_data[0]), 32'h16);
        check_eq("f1_ch_valid",   32'(snap_vld[0]),  32'b0100);
        check_eq("f2_latency",    32'(snap_cyc[1]),  32'(c0 + 22));
        check_eq("f2_shEn_cnt",   32'(snap_sh[1]),   32'd6);
        check_eq("f2_ch_addr",    32'(snap_addr[1]), 32'd1);
        check_eq("f2_data_len",   32'(snap_len[1]),  32'd0);
        check_eq("f2_data_out",   32'(snap_data[1]), 32'h00);
        check_eq("f2_ch_valid",   32'(snap_vld[1]),  32'b0010);
        check_eq("f1f2_err_cnt",  32'(err_cnt),      32'd0);
        check_eq("f2_done_pulse", 32'(done),         32'd0);

        // Bad stop bit, then a held-low line that must not start a frame
        send(32'b0_11_0010_01_0, 10);
        repeat (5) drive(1'b0);
        check_eq("stop_err_cnt",  32'(err_cnt),  32'd1);
        check_eq("stop_err_code", 32'(last_err), 32'd1);
        check_eq("stop_no_done",  32'(done_cnt), 32'd2);
        check_eq("resync_busy",   32'(busy),     32'd1);
        check_eq("resync_shEn",   32'(shEn),     32'd0);
        check_eq("stop_data_out", 32'(data_out), 32'h00);
        repeat (3) drive(1'b1);
        check_eq("resync_idle",   32'(busy),     32'd0);

        // Length 10 exceeds the 8-bit payload register
        send(32'b0_00_1010_1111111111_1, 18);
        drive(1'b1);
        drive(1'b1);
        check_eq("ovf_err_cnt",   32'(err_cnt),  32'd2);
        check_eq("ovf_err_code",  32'(last_err), 32'd2);
        check_eq("ovf_no_done",   32'(done_cnt), 32'd2);
        check_eq("ovf_ch_addr",   32'(ch_addr),  32'd1);
        check_eq("ovf_data_len",  32'(data_len), 32'd0);
        check_eq("ovf_data_out",  32'(data_out), 32'h00);

        // Reset asserted between edges during the third payload bit
        send(32'b0_01_0101, 7);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy",     32'(busy),     32'd0);
        check_eq("arst_shEn",     32'(shEn),     32'd0);
        check_eq("arst_ch_addr",  32'(ch_addr),  32'd0);
        serIn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b1);
        check_eq("arst_idle",     32'(busy),     32'd0);

        // Fresh frame after reset: addr 0 len 1 payload 1
        send(32'b0_00_0001_1_1, 9);
        drive(1'b1);
        drive(1'b1);
        check_eq("f5_done_cnt",   32'(done_cnt),     32'd3);
        check_eq("f5_ch_addr",    32'(snap_addr[2]), 32'd0);
        check_eq("f5_data_len",   32'(snap_len[2]),  32'd1);
        check_eq("f5_data_out",   32'(snap_data[2]), 32'h01);
        check_eq("f5_ch_valid",   32'(snap_vld[2]),  32'b0001);
        check_eq("f5_err_cnt",    32'(err_cnt),      32'd2);
        check_eq("stray_valid",   32'(stray_vld),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
